// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory with registered fetch port.
// Optional LOAD_CHECKSUM_EN adds a trailing checksum beat verified before RUN.
module instr_mem_loader #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              origclk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fetch_oob,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   prog_len
);

  localparam int PW    = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_prog_len;
  logic [DATA_W-1:0] r_instr;
  logic              r_ivalid;
  logic              r_oob;

  logic              w_ready;
  logic              w_wr_en;
  logic              w_ptr_clr;
  logic              w_len_set;
  logic              w_len_clr;
  logic              w_fetch;
  logic              w_in_rng;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_sum_ok;

  assign w_in_rng = ({1'b0, pc} < r_prog_len);
  assign w_rd_idx = pc[IDX_W-1:0];
  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sum_chk;

  assign w_sum_chk = r_sum + load_data;
  assign w_sum_ok  = (w_sum_chk == '0);

  always_ff @(posedge origclk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_ptr_clr) begin
      r_sum <= '0;
    end else if (w_wr_en) begin
      r_sum <= w_sum_chk;
    end
  end
`else
  assign w_sum_ok = 1'b0;
`endif

  always_ff @(posedge origclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_wr_en   = 1'b0;
    w_ptr_clr = 1'b0;
    w_len_set = 1'b0;
    w_len_clr = 1'b0;
    w_fetch   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_next    = S_LOAD;
          w_ptr_clr = 1'b1;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (load_valid) begin
          w_wr_en = 1'b1;
          // last beat takes priority over overflow at the final slot
          if (load_last) begin
            w_len_set = 1'b1;
`ifdef LOAD_CHECKSUM_EN
            w_next    = S_CSUM;
`else
            w_next    = S_RUN;
`endif
          end else if (r_wr_ptr == LAST_IDX) begin
            w_next = S_ERR;
          end
        end
      end
`ifdef LOAD_CHECKSUM_EN
      S_CSUM: begin
        w_ready = 1'b1;
        if (load_valid) begin
          w_next = w_sum_ok ? S_RUN : S_ERR;
        end
      end
`endif
      S_RUN: begin
        if (load_start) begin
          w_next    = S_LOAD;
          w_ptr_clr = 1'b1;
          w_len_clr = 1'b1;
        end else begin
          w_fetch = 1'b1;
        end
      end
      S_ERR: begin
        if (load_start) begin
          w_next    = S_LOAD;
          w_ptr_clr = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge origclk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_instr    <= NOP_WORD;
      r_ivalid   <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      if (w_ptr_clr)    r_wr_ptr <= '0;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;

      if (w_len_clr)      r_prog_len <= '0;
      else if (w_len_set) r_prog_len <= r_wr_ptr + 1'b1;

      if (w_fetch) begin
        r_instr  <= w_in_rng ? r_mem[w_rd_idx] : NOP_WORD;
        r_oob    <= ~w_in_rng;
        r_ivalid <= 1'b1;
      end else begin
        r_instr  <= NOP_WORD;
        r_oob    <= 1'b0;
        r_ivalid <= 1'b0;
      end
    end
  end

  // storage is never cleared; reset only blocks a write in flight
  always_ff @(posedge origclk) begin
    if (!reset && w_wr_en) r_mem[w_wr_idx] <= load_data;
  end

  assign load_ready  = w_ready;
  assign instruction = r_instr;
  assign instr_valid = r_ivalid;
  assign fetch_oob   = r_oob;
  assign state       = r_state;
  assign prog_len    = r_prog_len;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: default depth plus a DEPTH=4 instance.
// Checksum vectors run only when LOAD_CHECKSUM_EN is defined.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_start, load_valid, load_last;
  logic [7:0] load_data, pc;
  logic       load_ready, instr_valid, fetch_oob;
  logic [7:0] instruction;
  logic [2:0] state;
  logic [8:0] prog_len;

  logic       q_reset, q_start, q_valid, q_last;
  logic [7:0] q_data, q_pc;
  logic       q_ready, q_ivalid, q_oob;
  logic [7:0] q_instr;
  logic [2:0] q_state;
  logic [8:0] q_len;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] csum;

  instr_mem_loader dut (
    .origclk(clk), .reset(reset), .load_start(load_start),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .pc(pc),
    .instruction(instruction), .instr_valid(instr_valid),
    .fetch_oob(fetch_oob), .state(state), .prog_len(prog_len)
  );

  instr_mem_loader #(.DEPTH(4)) d4 (
    .origclk(clk), .reset(q_reset), .load_start(q_start),
    .load_valid(q_valid), .load_ready(q_ready),
    .load_data(q_data), .load_last(q_last), .pc(q_pc),
    .instruction(q_instr), .instr_valid(q_ivalid),
    .fetch_oob(q_oob), .state(q_state), .prog_len(q_len)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    csum       = csum + d;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic qbeat(input logic [7:0] d, input logic l);
    q_valid = 1'b1;
    q_data  = d;
    q_last  = l;
    tick();
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  // closes a load with the balancing beat when checksums are enabled
  task automatic close_load();
`ifdef LOAD_CHECKSUM_EN
    logic [7:0] t;
    t = 8'h00 - csum;
    beat(t, 1'b0);
`endif
  endtask

  task automatic start_main();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    csum = 8'h00;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
    load_last = 1'b0; load_data = 8'h00; pc = 8'h00;
    q_reset = 1'b1; q_start = 1'b0; q_valid = 1'b0;
    q_last = 1'b0; q_data = 8'h00; q_pc = 8'h00;
    csum = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    q_reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_len", 32'(prog_len), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_oob", 32'(fetch_oob), 32'd0);
    chk("rst_instr", 32'(instruction), 32'h00);

    load_valid = 1'b1;
    load_data  = 8'hAA;
    tick();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;

    start_main();
    chk("load_state", 32'(state), 32'd1);
    chk("load_ready", 32'(load_ready), 32'd1);
    beat(8'h71, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'hC2, 1'b1);
    close_load();
    chk("run_state", 32'(state), 32'd3);
    chk("run_len", 32'(prog_len), 32'd3);

    pc = 8'd1;
    tick();
    chk("pc1_instr", 32'(instruction), 32'h05);
    chk("pc1_valid", 32'(instr_valid), 32'd1);
    chk("pc1_oob", 32'(fetch_oob), 32'd0);
    pc = 8'd3;
    tick();
    chk("pc3_instr", 32'(instruction), 32'h00);
    chk("pc3_oob", 32'(fetch_oob), 32'd1);
    pc = 8'd0;
    tick();
    chk("pc0_instr", 32'(instruction), 32'h71);
    chk("pc0_oob", 32'(fetch_oob), 32'd0);

    start_main();
    chk("rl_state", 32'(state), 32'd1);
    chk("rl_ivalid", 32'(instr_valid), 32'd0);
    chk("rl_instr", 32'(instruction), 32'h00);
    chk("rl_oob", 32'(fetch_oob), 32'd0);
    chk("rl_len", 32'(prog_len), 32'd0);

    load_start = 1'b1;
    beat(8'h11, 1'b0);
    load_start = 1'b0;
    beat(8'h22, 1'b0);
    chk("ign_state", 32'(state), 32'd1);
    beat(8'h33, 1'b1);
    close_load();
    chk("ign_run", 32'(state), 32'd3);
    chk("ign_len", 32'(prog_len), 32'd3);
    pc = 8'd2;
    tick();
    chk("ign_pc2", 32'(instruction), 32'h33);
    pc = 8'd0;
    tick();
    chk("ign_pc0", 32'(instruction), 32'h11);

`ifdef LOAD_CHECKSUM_EN
    start_main();
    beat(8'h71, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'hC2, 1'b1);
    chk("cs_state", 32'(state), 32'd2);
    chk("cs_ready", 32'(load_ready), 32'd1);
    beat(8'hC8, 1'b1);
    chk("cs_good", 32'(state), 32'd3);
    start_main();
    beat(8'h71, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'hC2, 1'b1);
    beat(8'hC9, 1'b0);
    chk("cs_bad", 32'(state), 32'd4);
`endif

    start_main();
    chk("pre_rst", 32'(state), 32'd1);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h33;
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_len", 32'(prog_len), 32'd0);
    chk("mr_ready", 32'(load_ready), 32'd0);
    chk("mr_ivalid", 32'(instr_valid), 32'd0);

    q_start = 1'b1;
    tick();
    q_start = 1'b0;
    qbeat(8'hA0, 1'b0);
    qbeat(8'hA1, 1'b0);
    qbeat(8'hA2, 1'b0);
    chk("ov_mid", 32'(q_state), 32'd1);
    qbeat(8'hA3, 1'b0);
    chk("ov_state", 32'(q_state), 32'd4);
    chk("ov_ready", 32'(q_ready), 32'd0);
    q_start = 1'b1;
    tick();
    q_start = 1'b0;
    chk("ov_restart", 32'(q_state), 32'd1);
    chk("ov_rready", 32'(q_ready), 32'd1);

    qbeat(8'h01, 1'b0);
    qbeat(8'h02, 1'b0);
    qbeat(8'h03, 1'b0);
    qbeat(8'h04, 1'b1);
`ifdef LOAD_CHECKSUM_EN
    qbeat(8'hF6, 1'b0);
`endif
    chk("full_state", 32'(q_state), 32'd3);
    chk("full_len", 32'(q_len), 32'd4);
    q_pc = 8'd3;
    tick();
    chk("full_pc3", 32'(q_instr), 32'h04);
    chk("full_oob3", 32'(q_oob), 32'd0);
    q_pc = 8'd4;
    tick();
    chk("full_pc4", 32'(q_instr), 32'h00);
    chk("full_oob4", 32'(q_oob), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
